// File: rtl/hash_cfg_pkg.sv
// Shared types and helpers for the hash-table configuration path.
// Holds the loader state encoding and Q-matrix sizing/identity helpers.
package hash_cfg_pkg;

   localparam int MAX_KEY_WIDTH = 256;

   typedef enum logic [1:0] {
      LOAD        = 2'd0,
      DRAIN       = 2'd1,
      COMMIT_WAIT = 2'd2
   } loader_state_t;

   function automatic int total_words(input int tables, input int rows);
      return tables * rows;
   endfunction

   // Row r of an identity selection matrix: only key bit r feeds hash bit r.
   function automatic logic [MAX_KEY_WIDTH-1:0] identity_row(input int r, input int key_width);
      logic [MAX_KEY_WIDTH-1:0] row;
      if ((r >= 0) && (r < key_width) && (r < MAX_KEY_WIDTH)) begin
         row = {{(MAX_KEY_WIDTH-1){1'b0}}, 1'b1} << r;
      end else begin
         row = {MAX_KEY_WIDTH{1'b0}};
      end
      return row;
   endfunction

endpackage

// File: rtl/hash_matrix_shadow_regs.sv
// Register file with indexed word write and full-width flat read.
// Holds the matrix set being assembled before it is committed.
module hash_matrix_shadow_regs
   import hash_cfg_pkg::*;
#(
   parameter int DEPTH  = 88,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 7
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [WIDTH-1:0]         wdata,
   output logic [DEPTH*WIDTH-1:0]   rdata
);

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   logic [DEPTH*WIDTH-1:0] mem_r;

   // Storage: cleared only by reset, never between sets.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_r <= {(DEPTH*WIDTH){1'b0}};
      end else if (we && (waddr < DEPTH_A)) begin
         mem_r[waddr*WIDTH +: WIDTH] <= wdata;
      end
   end

   assign rdata = mem_r;

endmodule

// File: rtl/hash_matrix_loader.sv
// Assembles streamed H3 Q-matrix rows in a shadow buffer and commits them
// atomically to the hash table's matrix bus once the table is idle.
module hash_matrix_loader
   import hash_cfg_pkg::*;
#(
   parameter int KEY_WIDTH           = 32,
   parameter int NUMBER_OF_TABLES    = 8,
   parameter int HASH_TABLE_MAX_SIZE = 11
) (
   input  logic                                                  clk,
   input  logic                                                  reset,
   input  logic [KEY_WIDTH-1:0]                                  cfg_data_i,
   input  logic                                                  cfg_valid_i,
   input  logic                                                  cfg_last_i,
   output logic                                                  cfg_ready_o,
   input  logic                                                  table_idle_i,
   output logic [NUMBER_OF_TABLES*HASH_TABLE_MAX_SIZE*KEY_WIDTH-1:0] matrixes_o,
   output logic                                                  matrix_valid_o,
   output logic                                                  commit_o,
   output logic                                                  load_error_o,
   output logic                                                  busy_o
);

   localparam int TOTAL  = total_words(NUMBER_OF_TABLES, HASH_TABLE_MAX_SIZE);
   localparam int IDX_W  = $clog2(TOTAL);
   localparam int FLAT_W = TOTAL * KEY_WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

   function automatic logic [FLAT_W-1:0] identity_flat();
      logic [FLAT_W-1:0] flat;
      flat = {FLAT_W{1'b0}};
      for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
         for (int r = 0; r < HASH_TABLE_MAX_SIZE; r++) begin
            flat[(t*HASH_TABLE_MAX_SIZE + r)*KEY_WIDTH +: KEY_WIDTH] =
               KEY_WIDTH'(identity_row(r, KEY_WIDTH));
         end
      end
      return flat;
   endfunction

   localparam logic [FLAT_W-1:0] IDENTITY = identity_flat();

   loader_state_t     state_r, state_next;
   logic [IDX_W-1:0]  idx_r, idx_next;
   logic              ready_r, busy_r, commit_r, error_r, valid_r;
   logic              xfer_s, shadow_we_s, commit_next, error_next;
   logic [FLAT_W-1:0] active_r;
   logic [FLAT_W-1:0] shadow_s;

   hash_matrix_shadow_regs #(
      .DEPTH  (TOTAL),
      .WIDTH  (KEY_WIDTH),
      .ADDR_W (IDX_W)
   ) u_shadow (
      .clk   (clk),
      .reset (reset),
      .we    (shadow_we_s),
      .waddr (idx_r),
      .wdata (cfg_data_i),
      .rdata (shadow_s)
   );

   // Next-state, index and pulse decode for the load / drain / commit sequence.
   always_comb begin
      state_next  = state_r;
      idx_next    = idx_r;
      shadow_we_s = 1'b0;
      commit_next = 1'b0;
      error_next  = 1'b0;
      xfer_s      = cfg_valid_i && ready_r;
      case (state_r)
         LOAD: begin
            if (xfer_s) begin
               shadow_we_s = 1'b1;
               if (cfg_last_i) begin
                  idx_next = {IDX_W{1'b0}};
                  if (idx_r == LAST_IDX) begin
                     state_next = COMMIT_WAIT;
                  end else begin
                     error_next = 1'b1;
                  end
               end else if (idx_r == LAST_IDX) begin
                  error_next = 1'b1;
                  idx_next   = {IDX_W{1'b0}};
                  state_next = DRAIN;
               end else begin
                  idx_next = idx_r + IDX_W'(1);
               end
            end else begin
               state_next = LOAD;
            end
         end
         DRAIN: begin
            if (xfer_s && cfg_last_i) begin
               state_next = LOAD;
            end else begin
               state_next = DRAIN;
            end
         end
         COMMIT_WAIT: begin
            if (table_idle_i) begin
               commit_next = 1'b1;
               state_next  = LOAD;
            end else begin
               state_next = COMMIT_WAIT;
            end
         end
         default: begin
            state_next = LOAD;
            idx_next   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Control registers; ready and busy are precomputed so outputs stay registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= LOAD;
         idx_r    <= {IDX_W{1'b0}};
         ready_r  <= 1'b1;
         busy_r   <= 1'b0;
         commit_r <= 1'b0;
         error_r  <= 1'b0;
         valid_r  <= 1'b0;
      end else begin
         state_r  <= state_next;
         idx_r    <= idx_next;
         ready_r  <= (state_next != COMMIT_WAIT);
         busy_r   <= (state_next != LOAD) || (idx_next != {IDX_W{1'b0}});
         commit_r <= commit_next;
         error_r  <= error_next;
         if (commit_next) begin
            valid_r <= 1'b1;
         end
      end
   end

   // Active matrices: whole-set swap from the shadow in a single edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_r <= IDENTITY;
      end else if (commit_next) begin
         active_r <= shadow_s;
      end
   end

   assign cfg_ready_o    = ready_r;
   assign busy_o         = busy_r;
   assign commit_o       = commit_r;
   assign load_error_o   = error_r;
   assign matrix_valid_o = valid_r;
   assign matrixes_o     = active_r;

endmodule
